// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore sequence detector for a push-button input. It contains its own enable-tick
// divider and two-stage debounce, and recovers from a mismatch by falling back to the longest prefix.
module seq_detect_moore_param #(
   parameter int                 SEQ_LEN      = 4,
   parameter logic [SEQ_LEN-1:0] PATTERN      = 4'b1011,
   parameter bit                 OVERLAP      = 1'b0,
   parameter int                 DIV_DEBOUNCE = 18,
   parameter int                 DIV_STEP     = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               boton,
   output logic               boton_clean,
   output logic               seq_done,
   output logic [SEQ_LEN-1:0] step_leds,
   output logic [7:0]         match_count
);

   localparam int SW = $clog2(SEQ_LEN + 1);
   typedef logic [SW-1:0] match_len_t;

   localparam match_len_t         FULL    = match_len_t'(SEQ_LEN);
   localparam logic [SEQ_LEN-1:0] ONES    = {SEQ_LEN{1'b1}};
   localparam logic [SEQ_LEN-1:0] LED_ONE = {{(SEQ_LEN-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------
   // Divider and debounce
   // ------------------------------------------------------------------
   logic [DIV_STEP-1:0] clkdiv_q;
   logic                deb_tick;
   logic                step_tick;
   logic                d1_q;
   logic                d2_q;
   logic                boton_clean_q;

   assign deb_tick  = &clkdiv_q[DIV_DEBOUNCE-1:0];
   assign step_tick = &clkdiv_q;

   // NOTE: registers use non-blocking assignments, so d2_q takes the value d1_q held before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clkdiv_q      <= '0;
         d1_q          <= 1'b0;
         d2_q          <= 1'b0;
         boton_clean_q <= 1'b0;
      end else begin
         clkdiv_q <= clkdiv_q + DIV_STEP'(1);
         if (deb_tick) begin
            d1_q <= boton;
            d2_q <= d1_q;
         end
         boton_clean_q <= d1_q & d2_q;
      end
   end

   // ------------------------------------------------------------------
   // Match FSM: the state is the number of pattern bits matched so far
   // ------------------------------------------------------------------
   match_len_t         state_q;
   match_len_t         state_d;
   logic [SEQ_LEN-1:0] history_q;
   logic [SEQ_LEN-1:0] history_d;
   logic [7:0]         count_q;
   logic [7:0]         count_d;
   logic               seq_done_q;
   logic [SEQ_LEN-1:0] leds_q;
   logic [SEQ_LEN-1:0] leds_d;

   logic [SEQ_LEN:0]   cand;
   logic [SEQ_LEN:0]   pat_k;
   logic [SEQ_LEN:0]   mask_k;
   int                 cand_len;
   int                 best_k;

   // cand holds the newest sample in bit 0. A length-k candidate matches when its low k bits
   // equal the top k bits of PATTERN.
   always_comb begin
      cand     = {history_q, boton_clean_q};
      cand_len = ((int'(state_q) < SEQ_LEN - 1) ? int'(state_q) : SEQ_LEN - 1) + 1;
      best_k   = 0;
      pat_k    = '0;
      mask_k   = '0;
      for (int k = 1; k <= SEQ_LEN; k++) begin
         pat_k  = {1'b0, PATTERN >> (SEQ_LEN - k)};
         mask_k = {1'b0, ONES >> (SEQ_LEN - k)};
         if ((k <= cand_len) && (((cand ^ pat_k) & mask_k) == '0)) begin
            best_k = k;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      history_d = history_q;
      count_d   = count_q;
      if (step_tick) begin
         if ((state_q == FULL) && !OVERLAP) begin
            state_d   = '0;
            history_d = '0;
         end else begin
            state_d   = match_len_t'(best_k);
            history_d = {history_q[SEQ_LEN-2:0], boton_clean_q};
         end
         if ((state_d == FULL) && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
         end
      end
   end

   // The outputs are registered from the next state, so they always equal the decode of state_q.
   always_comb begin
      leds_d = '0;
      if (state_d != '0) begin
         leds_d = LED_ONE << (SEQ_LEN - int'(state_d));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= '0;
         history_q  <= '0;
         count_q    <= '0;
         seq_done_q <= 1'b0;
         leds_q     <= '0;
      end else begin
         state_q    <= state_d;
         history_q  <= history_d;
         count_q    <= count_d;
         seq_done_q <= (state_d == FULL);
         leds_q     <= leds_d;
      end
   end

   assign boton_clean = boton_clean_q;
   assign seq_done    = seq_done_q;
   assign step_leds   = leds_q;
   assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Bench for seq_detect_moore_param: three configurations share one button and are checked
// against a queue-based model of the prefix/suffix matching rule.
module tb_seq_detect_moore_param;

   localparam int STEP_CLKS = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       boton;
   logic       clean_a, clean_b, clean_c;
   logic       done_a, done_b, done_c;
   logic [3:0] leds_a, leds_b;
   logic [1:0] leds_c;
   logic [7:0] cnt_a, cnt_b, cnt_c;

   always #5 clk = ~clk;

   seq_detect_moore_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0),
                            .DIV_DEBOUNCE(2), .DIV_STEP(5)) dut_a (
      .clk(clk), .rst(rst), .boton(boton), .boton_clean(clean_a),
      .seq_done(done_a), .step_leds(leds_a), .match_count(cnt_a));

   seq_detect_moore_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1),
                            .DIV_DEBOUNCE(2), .DIV_STEP(5)) dut_b (
      .clk(clk), .rst(rst), .boton(boton), .boton_clean(clean_b),
      .seq_done(done_b), .step_leds(leds_b), .match_count(cnt_b));

   seq_detect_moore_param #(.SEQ_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1),
                            .DIV_DEBOUNCE(2), .DIV_STEP(5)) dut_c (
      .clk(clk), .rst(rst), .boton(boton), .boton_clean(clean_c),
      .seq_done(done_c), .step_leds(leds_c), .match_count(cnt_c));

   int n_tests = 0;
   int n_fail  = 0;

   int m_len[3] = '{4, 4, 2};
   int m_pat[3] = '{11, 11, 3};
   bit m_ovl[3] = '{1'b0, 1'b1, 1'b1};
   int m_state[3];
   int m_count[3];
   bit samples[$];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_state[i] = 0;
         m_count[i] = 0;
      end
      samples.delete();
   endtask

   // Next state = longest tail of (recent samples + b) that equals a head of the pattern.
   task automatic model_step(input bit b);
      for (int i = 0; i < 3; i++) begin
         int nst;
         int keep;
         bit ok;
         bit cand[$];
         nst = 0;
         if (!(m_state[i] == m_len[i] && !m_ovl[i])) begin
            keep = (m_state[i] < m_len[i] - 1) ? m_state[i] : m_len[i] - 1;
            cand.delete();
            for (int j = samples.size() - keep; j < samples.size(); j++) cand.push_back(samples[j]);
            cand.push_back(b);
            for (int k = cand.size(); k >= 1 && nst == 0; k--) begin
               ok = 1'b1;
               for (int j = 0; j < k; j++) begin
                  if (cand[cand.size() - k + j] != m_pat[i][m_len[i] - 1 - j]) ok = 1'b0;
               end
               if (ok) nst = k;
            end
         end
         if (nst == m_len[i] && m_count[i] < 255) m_count[i]++;
         m_state[i] = nst;
      end
      samples.push_back(b);
      if (samples.size() > 32) void'(samples.pop_front());
   endtask

   function automatic int exp_leds(input int i);
      return (m_state[i] == 0) ? 0 : (1 << (m_len[i] - m_state[i]));
   endfunction

   task automatic check_inst(input string nm, input int i, input logic sd,
                             input logic [31:0] leds, input logic [7:0] cnt);
      check({nm, ".seq_done"}, 32'(sd), 32'(m_state[i] == m_len[i]));
      check({nm, ".step_leds"}, leds, exp_leds(i));
      check({nm, ".match_count"}, 32'(cnt), m_count[i]);
   endtask

   task automatic check_all();
      check_inst("A", 0, done_a, {28'b0, leds_a}, cnt_a);
      check_inst("B", 1, done_b, {28'b0, leds_b}, cnt_b);
      check_inst("C", 2, done_c, {30'b0, leds_c}, cnt_c);
   endtask

   // Entered just after a step update; boton is held for a full step so it is fully debounced.
   task automatic do_step(input bit b);
      boton = b;
      tick(STEP_CLKS);
      model_step(b);
      check_all();
   endtask

   task automatic run_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) do_step(bits[i]);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [4:0]  seq3;
      logic [19:0] exp3;
      logic [31:0] deb_pat;

      rst   = 1'b1;
      boton = 1'b0;

      // Plain match 1,0,1,1
      reset_dut();
      run_bits(32'b1011, 4);
      check("A.count_1011", 32'(cnt_a), 32'd1);
      check("A.done_1011", 32'(done_a), 32'd1);

      // Mismatch fallback keeps state 1 on the repeated leading one
      reset_dut();
      seq3 = 5'b11011;
      exp3 = {4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
      for (int i = 0; i < 5; i++) begin
         do_step(seq3[4 - i]);
         check("A.fallback_leds", 32'(leds_a), 32'(exp3[19 - 4*i -: 4]));
      end
      check("A.fallback_count", 32'(cnt_a), 32'd1);

      // Overlap versus non-overlap on 1,0,1,1,0,1,1
      reset_dut();
      run_bits(32'b1011011, 7);
      check("B.overlap_count", 32'(cnt_b), 32'd2);
      check("B.overlap_done", 32'(done_b), 32'd1);
      check("A.nonoverlap_count", 32'(cnt_a), 32'd1);
      check("A.nonoverlap_leds", 32'(leds_a), 32'b1000);

      // Reset in the middle of a partial match after three completed matches
      reset_dut();
      run_bits(32'b10110101101011010, 17);
      check("A.pre_rst_count", 32'(cnt_a), 32'd3);
      check("A.pre_rst_leds", 32'(leds_a), 32'b0100);
      boton = 1'b1;
      tick(15);
      check("A.pre_rst_clean", 32'(clean_a), 32'd1);
      rst = 1'b1;
      tick(1);
      check("A.rst_done", 32'(done_a), 32'd0);
      check("A.rst_leds", 32'(leds_a), 32'd0);
      check("A.rst_count", 32'(cnt_a), 32'd0);
      check("A.rst_clean", 32'(clean_a), 32'd0);
      check("B.rst_count", 32'(cnt_b), 32'd0);
      check("B.rst_clean", 32'(clean_b), 32'd0);
      check("C.rst_count", 32'(cnt_c), 32'd0);
      check("C.rst_clean", 32'(clean_c), 32'd0);
      check("C.rst_done", 32'(done_c), 32'd0);
      rst = 1'b0;
      model_reset();
      tick(31);
      check("A.no_step_before_31", 32'(leds_a), 32'd0);
      tick(1);
      model_step(1'b1);
      check_all();
      check("A.first_step_leds", 32'(leds_a), 32'b1000);

      // Debounce: short pulse, single-sample bounce, then a stable press from cycle 16
      reset_dut();
      deb_pat = 32'hFFFF_2870;
      for (int c = 0; c < 32; c++) begin
         check("A.debounce_clean", 32'(clean_a), 32'(c >= 25));
         boton = deb_pat[c];
         tick(1);
      end
      model_step(1'b1);
      check_all();

      // Held press: periodic pattern keeps C matched and saturates its counter
      reset_dut();
      for (int i = 0; i < 300; i++) do_step(1'b1);
      check("C.sat_count", 32'(cnt_c), 32'd255);
      check("C.sat_done", 32'(done_c), 32'd1);

      // Random button sequence
      reset_dut();
      for (int i = 0; i < 80; i++) do_step(1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
